// File: rtl/logistic_map_gen_pkg.sv
// ============================================================================
// Module : logistic_pkg
// Shared FSM encoding, fixed-point r bounds and index-width helper for the
// logistic-map frequency generator.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package logistic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL1 = 2'd1,
        ST_MUL2 = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // r = 3.0 and r = 4.0 in Q2.frac
    function automatic longint r_three(input int frac);
        return longint'(3) << frac;
    endfunction

    function automatic longint r_four(input int frac);
        return longint'(4) << frac;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/logistic_map_gen_mul.sv
// ============================================================================
// Module : mul_seq_u
// Unsigned shift-add multiplier; walks the B operand one bit per cycle for
// exactly B_W cycles (the start cycle included), done pulses the cycle after.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mul_seq_u #(
    parameter int A_W = 18,
    parameter int B_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [A_W-1:0]       i_a,
    input  logic [B_W-1:0]       i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [A_W+B_W-1:0]   o_prod
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(B_W) + 1;

    logic [P_W-1:0]   r_acc;
    logic [P_W-1:0]   r_a_sh;
    logic [B_W-1:0]   r_b_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                // bit 0 is consumed in the start cycle itself
                r_acc  <= i_b[0] ? P_W'(i_a) : '0;
                r_a_sh <= P_W'(i_a) << 1;
                r_b_sh <= i_b >> 1;
                r_cnt  <= CNT_W'(1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_b_sh[0]) begin
                    r_acc <= r_acc + r_a_sh;
                end
                r_a_sh <= r_a_sh << 1;
                r_b_sh <= r_b_sh >> 1;
                r_cnt  <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(B_W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_prod = r_acc;

endmodule

`default_nettype wire

// File: rtl/logistic_map_gen.sv
// ============================================================================
// Module : logistic_map_gen
// Frame-paced logistic-map iterator x <- r*x*(1-x) with r sweep; optional
// r_hold input when LOGISTIC_R_HOLD_EN is defined.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module logistic_map_gen
    import logistic_pkg::*;
#(
    parameter int N_OSC    = 8,
    parameter int ITER_LEN = 15361,
    parameter int R_INC    = 2,
    parameter int FRAC     = 16,
    parameter int X0       = 12288
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [FRAC-1:0]           x_out,
    output logic [idx_w(N_OSC)-1:0]   idx,
    output logic                      valid,
    input  logic                      ready,
    output logic                      frame_start,
`ifdef LOGISTIC_R_HOLD_EN
    input  logic                      r_hold,
`endif
    output logic [FRAC+1:0]           r_out
);

    localparam int W_IDX = idx_w(N_OSC);
    localparam int CNT_W = (ITER_LEN > 1) ? $clog2(ITER_LEN) : 1;
    localparam logic [FRAC+1:0] c_R_THREE = (FRAC+2)'(r_three(FRAC));
    localparam logic [FRAC+2:0] c_R_FOUR  = (FRAC+3)'(r_four(FRAC));
    localparam logic [FRAC-1:0] c_X0      = FRAC'(X0);

    generate
        if (ITER_LEN < N_OSC * (2 * FRAC + 2)) begin : g_bad_iter_len
            $error("ITER_LEN shorter than N_OSC*(2*FRAC+2)");
        end
        if (X0 == 0) begin : g_bad_x0
            $error("X0 must be nonzero");
        end
    endgenerate

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pend;
    logic [FRAC-1:0]    r_x;
    logic [FRAC+1:0]    r_r;
    logic [FRAC-1:0]    r_x_out;
    logic [W_IDX-1:0]   r_idx;
    logic               r_valid;
    logic               r_fs;
    logic               r_go;

    logic               w_tick;
    logic [FRAC:0]      w_one_m_x;
    logic               w_second;
    logic               w_mul_start;
    logic [FRAC+1:0]    w_mul_a;
    logic [FRAC-1:0]    w_mul_b;
    logic [2*FRAC+1:0]  w_prod;
    logic [FRAC-1:0]    w_prod_q;
    logic               w_mul_done;
    logic               w_mul_busy;
    logic [FRAC+2:0]    w_unused;
    logic [FRAC-1:0]    w_x_next;
    logic [FRAC+2:0]    w_r_sum;
    logic [FRAC+1:0]    w_r_next;
    logic               w_r_adv;

    assign w_tick    = (r_cnt == CNT_W'(ITER_LEN - 1));
    assign w_one_m_x = {1'b1, {FRAC{1'b0}}} - {1'b0, r_x};

    // The r*p pass starts in the very cycle the x*(1-x) pass reports done,
    // feeding p straight from the product bus.
    assign w_second    = (r_state == ST_MUL1) && w_mul_done;
    assign w_mul_start = r_go || w_second;
    assign w_mul_a     = w_second ? r_r : {1'b0, w_one_m_x};
    assign w_mul_b     = w_second ? w_prod_q : r_x;
    assign w_prod_q    = w_prod[2*FRAC-1:FRAC];
    assign w_unused    = {w_prod[2*FRAC+1:2*FRAC], w_prod[FRAC-1:0], w_mul_busy};

    assign w_x_next = (w_prod_q == '0) ? c_X0 : w_prod_q;
    assign w_r_sum  = {1'b0, r_r} + (FRAC+3)'(R_INC);
    assign w_r_next = (w_r_sum >= c_R_FOUR) ? c_R_THREE : w_r_sum[FRAC+1:0];

`ifdef LOGISTIC_R_HOLD_EN
    assign w_r_adv = !r_hold;
`else
    assign w_r_adv = 1'b1;
`endif

    mul_seq_u #(
        .A_W (FRAC + 2),
        .B_W (FRAC)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_mul_start),
        .i_a     (w_mul_a),
        .i_b     (w_mul_b),
        .o_busy  (w_mul_busy),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_x     <= c_X0;
            r_r     <= c_R_THREE;
            r_x_out <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_fs    <= 1'b0;
            r_go    <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_fs  <= 1'b0;
            r_go  <= 1'b0;
            if (r_state != ST_IDLE && w_tick) begin
                r_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_tick || r_pend) begin
                        r_state <= ST_MUL1;
                        r_idx   <= '0;
                        r_fs    <= 1'b1;
                        r_go    <= 1'b1;
                        r_pend  <= 1'b0;
                    end
                end
                ST_MUL1: begin
                    if (w_mul_done) begin
                        r_state <= ST_MUL2;
                    end
                end
                ST_MUL2: begin
                    if (w_mul_done) begin
                        r_x     <= w_x_next;
                        r_x_out <= w_x_next;
                        r_valid <= 1'b1;
                        r_state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (ready) begin
                        r_valid <= 1'b0;
                        if (r_idx == W_IDX'(N_OSC - 1)) begin
                            r_state <= ST_IDLE;
                            if (w_r_adv) begin
                                r_r <= w_r_next;
                            end
                        end else begin
                            r_idx   <= r_idx + W_IDX'(1);
                            r_go    <= 1'b1;
                            r_state <= ST_MUL1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign x_out       = r_x_out;
    assign idx         = r_idx;
    assign valid       = r_valid;
    assign frame_start = r_fs;
    assign r_out       = r_r;

endmodule

`default_nettype wire
